// File: rtl/ex_arith_logic_unit_if.sv
// Operand/result bundle between the ID operand latch and the EX arithmetic/logic unit.
// The master side drives funct, operands and the divide request; the slave side is the ALU.
interface ex_arith_logic_unit_if #(
    parameter int DATA_W = 32
);
    logic [5:0]        funct;
    logic [4:0]        shamt;
    logic [DATA_W-1:0] operand_1;
    logic [DATA_W-1:0] operand_2;
    logic              div_start;
    logic [DATA_W-1:0] result;
    logic              overflow;
    logic              div_busy;
    logic              div_done;
    logic [DATA_W-1:0] hi_out;
    logic [DATA_W-1:0] lo_out;

    modport master (
        output funct, shamt, operand_1, operand_2, div_start,
        input  result, overflow, div_busy, div_done, hi_out, lo_out
    );

    modport slave (
        input  funct, shamt, operand_1, operand_2, div_start,
        output result, overflow, div_busy, div_done, hi_out, lo_out
    );
endinterface

// File: rtl/ex_arith_logic_unit.sv
// EX-stage ALU: combinational add/compare/logic/shift result plus an iterative
// restoring divider (DIV/DIVU) that reports quotient on lo_out and remainder on hi_out.
module ex_arith_logic_unit #(
    parameter int DATA_W = 32
) (
    input logic                  clk,
    input logic                  rst_n,
    ex_arith_logic_unit_if.slave alu_if
);
    localparam int MSB   = DATA_W - 1;
    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [5:0] {
        F_SLL  = 6'h00, F_SRL  = 6'h02, F_SRA  = 6'h03,
        F_SLLV = 6'h04, F_SRLV = 6'h06, F_SRAV = 6'h07,
        F_DIV  = 6'h1A, F_DIVU = 6'h1B,
        F_ADD  = 6'h20, F_ADDU = 6'h21, F_SUB  = 6'h22, F_SUBU = 6'h23,
        F_AND  = 6'h24, F_OR   = 6'h25, F_XOR  = 6'h26, F_NOR  = 6'h27,
        F_SLT  = 6'h2A, F_SLTU = 6'h2B
    } funct_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } div_state_e;

    logic [DATA_W-1:0] op1, op2;
    logic [DATA_W-1:0] sum, diff;
    logic [DATA_W-1:0] alu_result;
    logic              alu_overflow;

    assign op1  = alu_if.operand_1;
    assign op2  = alu_if.operand_2;
    assign sum  = op1 + op2;
    assign diff = op1 - op2;

    // NOTE: every variable written in an always_comb gets a default first, so no path infers a latch.
    always_comb begin
        alu_result   = '0;
        alu_overflow = 1'b0;
        case (alu_if.funct)
            F_ADD: begin
                alu_result   = sum;
                alu_overflow = (op1[MSB] == op2[MSB]) && (sum[MSB] != op1[MSB]);
            end
            F_ADDU: alu_result = sum;
            F_SUB: begin
                alu_result   = diff;
                alu_overflow = (op1[MSB] != op2[MSB]) && (diff[MSB] != op1[MSB]);
            end
            F_SUBU: alu_result = diff;
            F_SLT:  alu_result = DATA_W'($signed(op1) < $signed(op2));
            F_SLTU: alu_result = DATA_W'(op1 < op2);
            F_AND:  alu_result = op1 & op2;
            F_OR:   alu_result = op1 | op2;
            F_XOR:  alu_result = op1 ^ op2;
            F_NOR:  alu_result = ~(op1 | op2);
            F_SLL:  alu_result = op2 << alu_if.shamt;
            F_SRL:  alu_result = op2 >> alu_if.shamt;
            F_SRA:  alu_result = $signed(op2) >>> alu_if.shamt;
            F_SLLV: alu_result = op2 << op1[4:0];
            F_SRLV: alu_result = op2 >> op1[4:0];
            F_SRAV: alu_result = $signed(op2) >>> op1[4:0];
            default: alu_result = '0;
        endcase
    end

    assign alu_if.result   = alu_result;
    assign alu_if.overflow = alu_overflow;

    // Divider state: quot_q starts as |dividend| and is shifted out MSB-first as quotient bits enter.
    div_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] quot_q, quot_d;
    logic [DATA_W-1:0] rem_q, rem_d;
    logic [DATA_W-1:0] divisor_q, divisor_d;
    logic              q_neg_q, q_neg_d;
    logic              r_neg_q, r_neg_d;
    logic              zero_q, zero_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;

    logic              is_div, is_signed;
    logic [DATA_W:0]   rem_shift, trial;

    assign is_div    = (alu_if.funct == F_DIV) || (alu_if.funct == F_DIVU);
    assign is_signed = (alu_if.funct == F_DIV);
    assign rem_shift = {rem_q, quot_q[MSB]};
    assign trial     = rem_shift - {1'b0, divisor_q};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        quot_d    = quot_q;
        rem_d     = rem_q;
        divisor_d = divisor_q;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;
        zero_d    = zero_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        unique case (state_q)
            S_IDLE: begin
                if (alu_if.div_start && is_div) begin
                    state_d   = S_CALC;
                    cnt_d     = '0;
                    rem_d     = '0;
                    zero_d    = (op2 == '0);
                    q_neg_d   = is_signed && (op1[MSB] ^ op2[MSB]);
                    r_neg_d   = is_signed && op1[MSB];
                    quot_d    = (is_signed && op1[MSB]) ? -op1 : op1;
                    divisor_d = (is_signed && op2[MSB]) ? -op2 : op2;
                end
            end
            S_CALC: begin
                if (zero_q) begin
                    // Divide by zero: all-ones quotient, remainder is the dividend as issued.
                    state_d = S_DONE;
                    lo_d    = '1;
                    hi_d    = r_neg_q ? -quot_q : quot_q;
                end else if (cnt_q == CNT_W'(DATA_W)) begin
                    state_d = S_DONE;
                    lo_d    = q_neg_q ? -quot_q : quot_q;
                    hi_d    = r_neg_q ? -rem_q : rem_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (trial[DATA_W]) begin
                        rem_d  = rem_shift[MSB:0];
                        quot_d = {quot_q[MSB-1:0], 1'b0};
                    end else begin
                        rem_d  = trial[MSB:0];
                        quot_d = {quot_q[MSB-1:0], 1'b1};
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            quot_q    <= '0;
            rem_q     <= '0;
            divisor_q <= '0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            zero_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
            divisor_q <= divisor_d;
            q_neg_q   <= q_neg_d;
            r_neg_q   <= r_neg_d;
            zero_q    <= zero_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign alu_if.div_busy = (state_q == S_CALC);
    assign alu_if.div_done = (state_q == S_DONE);
    assign alu_if.hi_out   = hi_q;
    assign alu_if.lo_out   = lo_q;

endmodule

// File: tb/tb_ex_arith_logic_unit.sv
// Directed-vector bench for ex_arith_logic_unit: combinational ALU table plus
// divider latency, handshake, sign rules, divide-by-zero and reset-abort sequences.
module tb_ex_arith_logic_unit;
    logic clk;
    logic rst_n;
    int   n_total;
    int   n_passed;

    ex_arith_logic_unit_if #(.DATA_W(32)) alu_if ();

    ex_arith_logic_unit #(.DATA_W(32)) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .alu_if (alu_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]  f;
        logic [4:0]  sh;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        ov;
    } vec_t;

    vec_t vecs [22];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
        else
            n_passed++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses div_start, then observes 40 post-edge samples (k=0 is just after the start edge).
    task automatic run_div(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                           input bit second_start,
                           output int busy_n, output int done_n, output int done_at);
        alu_if.funct     = f;
        alu_if.operand_1 = a;
        alu_if.operand_2 = b;
        alu_if.div_start = 1'b1;
        tick();
        alu_if.div_start = 1'b0;
        busy_n  = 0;
        done_n  = 0;
        done_at = -1;
        for (int k = 0; k < 40; k++) begin
            if (alu_if.div_busy) busy_n++;
            if (alu_if.div_done) begin
                done_n++;
                done_at = k;
            end
            if (second_start && k == 5) begin
                alu_if.operand_1 = 32'd12345;
                alu_if.operand_2 = 32'd3;
                alu_if.div_start = 1'b1;
            end else begin
                alu_if.div_start = 1'b0;
            end
            tick();
        end
    endtask

    initial begin
        int busy_n, done_n, done_at;
        n_total  = 0;
        n_passed = 0;

        vecs = '{
            '{6'h20, 5'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1},
            '{6'h21, 5'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0},
            '{6'h22, 5'd0,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1},
            '{6'h2A, 5'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0},
            '{6'h2B, 5'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0},
            '{6'h27, 5'd0,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0},
            '{6'h26, 5'd0,  32'hF0F0F0F0, 32'hFFFF0000, 32'h0F0FF0F0, 1'b0},
            '{6'h03, 5'd4,  32'h00000000, 32'h80000000, 32'hF8000000, 1'b0},
            '{6'h04, 5'd7,  32'h00000021, 32'h00000003, 32'h00000006, 1'b0},
            '{6'h02, 5'd4,  32'h00000000, 32'h80000000, 32'h08000000, 1'b0},
            '{6'h07, 5'd0,  32'h0000001F, 32'h80000000, 32'hFFFFFFFF, 1'b0},
            '{6'h24, 5'd0,  32'hF0F0F0F0, 32'hFFFF0000, 32'hF0F00000, 1'b0},
            '{6'h25, 5'd0,  32'hF0F0F0F0, 32'hFFFF0000, 32'hFFFFF0F0, 1'b0},
            '{6'h22, 5'd0,  32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0},
            '{6'h20, 5'd0,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0},
            '{6'h06, 5'd0,  32'h00000008, 32'h12345678, 32'h00123456, 1'b0},
            '{6'h00, 5'd31, 32'h00000000, 32'h00000001, 32'h80000000, 1'b0},
            '{6'h1A, 5'd0,  32'h00000064, 32'h00000007, 32'h00000000, 1'b0},
            '{6'h3F, 5'd0,  32'h7FFFFFFF, 32'h00000001, 32'h00000000, 1'b0},
            '{6'h22, 5'd0,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b1},
            '{6'h2A, 5'd0,  32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0},
            '{6'h2B, 5'd0,  32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b0}
        };

        rst_n            = 1'b0;
        alu_if.funct     = 6'h00;
        alu_if.shamt     = 5'd0;
        alu_if.operand_1 = '0;
        alu_if.operand_2 = '0;
        alu_if.div_start = 1'b0;
        tick();
        tick();
        check("rst_busy", 32'(alu_if.div_busy), 32'd0);
        check("rst_done", 32'(alu_if.div_done), 32'd0);
        check("rst_hi",   alu_if.hi_out, 32'd0);
        check("rst_lo",   alu_if.lo_out, 32'd0);
        rst_n = 1'b1;
        tick();

        foreach (vecs[i]) begin
            alu_if.funct     = vecs[i].f;
            alu_if.shamt     = vecs[i].sh;
            alu_if.operand_1 = vecs[i].a;
            alu_if.operand_2 = vecs[i].b;
            #1;
            check($sformatf("alu_res[%0d]", i), alu_if.result, vecs[i].r);
            check($sformatf("alu_ovf[%0d]", i), 32'(alu_if.overflow), 32'(vecs[i].ov));
        end
        tick();

        run_div(6'h1A, 32'hFFFFFFF9, 32'h00000002, 1'b0, busy_n, done_n, done_at);
        check("div_m7_busy_cycles", 32'(busy_n), 32'd33);
        check("div_m7_done_count",  32'(done_n), 32'd1);
        check("div_m7_done_at",     32'(done_at), 32'd33);
        check("div_m7_lo", alu_if.lo_out, 32'hFFFFFFFD);
        check("div_m7_hi", alu_if.hi_out, 32'hFFFFFFFF);

        // Abort after E10; div_start held high across the reset edge must be ignored.
        alu_if.funct     = 6'h1A;
        alu_if.operand_1 = 32'd100;
        alu_if.operand_2 = 32'd7;
        alu_if.div_start = 1'b1;
        tick();
        alu_if.div_start = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        check("abort_busy_before", 32'(alu_if.div_busy), 32'd1);
        rst_n            = 1'b0;
        alu_if.div_start = 1'b1;
        tick();
        check("abort_busy", 32'(alu_if.div_busy), 32'd0);
        check("abort_done", 32'(alu_if.div_done), 32'd0);
        check("abort_hi",   alu_if.hi_out, 32'd0);
        check("abort_lo",   alu_if.lo_out, 32'd0);
        rst_n            = 1'b1;
        alu_if.div_start = 1'b0;
        done_n = 0;
        busy_n = 0;
        for (int k = 0; k < 40; k++) begin
            if (alu_if.div_done) done_n++;
            if (alu_if.div_busy) busy_n++;
            tick();
        end
        check("abort_no_done", 32'(done_n), 32'd0);
        check("abort_no_busy", 32'(busy_n), 32'd0);

        run_div(6'h1B, 32'd100, 32'd7, 1'b0, busy_n, done_n, done_at);
        check("divu_100_7_lo", alu_if.lo_out, 32'd14);
        check("divu_100_7_hi", alu_if.hi_out, 32'd2);
        check("divu_100_7_done_count", 32'(done_n), 32'd1);

        run_div(6'h1B, 32'd7, 32'd0, 1'b0, busy_n, done_n, done_at);
        check("divz_done_at",    32'(done_at), 32'd1);
        check("divz_done_count", 32'(done_n), 32'd1);
        check("divz_lo", alu_if.lo_out, 32'hFFFFFFFF);
        check("divz_hi", alu_if.hi_out, 32'd7);

        run_div(6'h1A, 32'h80000000, 32'hFFFFFFFF, 1'b0, busy_n, done_n, done_at);
        check("div_min_lo", alu_if.lo_out, 32'h80000000);
        check("div_min_hi", alu_if.hi_out, 32'd0);

        run_div(6'h1A, 32'd7, 32'hFFFFFFFE, 1'b0, busy_n, done_n, done_at);
        check("div_7_m2_lo", alu_if.lo_out, 32'hFFFFFFFD);
        check("div_7_m2_hi", alu_if.hi_out, 32'd1);

        run_div(6'h1B, 32'd1000, 32'd9, 1'b1, busy_n, done_n, done_at);
        check("busy_start_done_count", 32'(done_n), 32'd1);
        check("busy_start_busy",       32'(busy_n), 32'd33);
        check("busy_start_lo", alu_if.lo_out, 32'd111);
        check("busy_start_hi", alu_if.hi_out, 32'd1);

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule
